// File: rtl/item_puller_if.sv
// Item handshake bundle between the last pusher stage, the puller and its consumer.
// The puller uses the slave view; whoever drives items and pulls uses the master view.
interface item_puller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] item_in;
    logic                  item_in_valid;
    logic                  item_in_ready;
    logic                  pull_req;
    logic [DATA_WIDTH-1:0] pull_data;
    logic                  pull_ack;
    logic                  pull_underflow;
    logic [LVL_W-1:0]      level;
    logic [CNT_WIDTH-1:0]  recv_count;

    modport slave (
        input  item_in, item_in_valid, pull_req,
        output item_in_ready, pull_data, pull_ack, pull_underflow, level, recv_count
    );

    modport master (
        output item_in, item_in_valid, pull_req,
        input  item_in_ready, pull_data, pull_ack, pull_underflow, level, recv_count
    );
endinterface

// File: rtl/item_puller.sv
// Receives pushed items into a small circular FIFO and hands them out one per pull request,
// counting every accepted item (wrapping).
module item_puller #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic          clock,
    input logic          reset,
    item_puller_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic [CNT_WIDTH-1:0]  recv_count;
    logic [DATA_WIDTH-1:0] pull_data;
    logic                  pull_ack;
    logic                  pull_underflow;
    logic                  ready;
    logic                  push;
    logic                  pull;

    // Ready comes only from registered occupancy, so a same-cycle pull never opens a slot.
    assign ready = (level != LVL_W'(DEPTH));
    assign push  = bus.item_in_valid && ready;
    // No bypass: an empty FIFO underflows even if a push lands in the same cycle.
    assign pull  = bus.pull_req && (level != '0);

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr] <= bus.item_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            recv_count     <= '0;
            pull_data      <= '0;
            pull_ack       <= 1'b0;
            pull_underflow <= 1'b0;
        end else begin
            pull_ack       <= pull;
            pull_underflow <= bus.pull_req && !pull;
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                recv_count <= recv_count + 1'b1;
            end
            if (pull) begin
                pull_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (push && !pull) begin
                level <= level + 1'b1;
            end else if (pull && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    assign bus.item_in_ready  = ready;
    assign bus.pull_data      = pull_data;
    assign bus.pull_ack       = pull_ack;
    assign bus.pull_underflow = pull_underflow;
    assign bus.level          = level;
    assign bus.recv_count     = recv_count;
endmodule

// File: tb/tb_item_puller.sv
// Directed bench for item_puller: a queue scoreboard receives each accepted item and is
// popped whenever the DUT acknowledges a pull.
module tb_item_puller;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    item_puller_if #(.DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)) bus ();

    item_puller #(.DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    logic [DW-1:0] sb[$];
    int          mlevel = 0;
    logic [CW-1:0] mcount = '0;
    logic [DW-1:0] mdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, advance, compare.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        logic acc;
        logic pl;
        bus.item_in_valid = v;
        bus.item_in       = d;
        bus.pull_req      = r;
        check("ready", 32'(bus.item_in_ready), 32'(mlevel != DP));
        acc = v && (mlevel != DP);
        pl  = r && (mlevel != 0);
        if (acc) begin
            sb.push_back(d);
            mcount = mcount + 1'b1;
        end
        @(posedge clock);
        #1;
        if (acc) mlevel++;
        if (pl)  mlevel--;
        check("ack", 32'(bus.pull_ack), 32'(pl));
        check("underflow", 32'(bus.pull_underflow), 32'(r && !pl));
        if (bus.pull_ack) begin
            if (sb.size() > 0) mdata = sb.pop_front();
            check("pull_data", 32'(bus.pull_data), 32'(mdata));
        end else begin
            check("data_hold", 32'(bus.pull_data), 32'(mdata));
        end
        check("level", 32'(bus.level), 32'(mlevel));
        check("recv_count", 32'(bus.recv_count), 32'(mcount));
    endtask

    task automatic do_reset(input logic v, input logic r);
        reset             = 1'b0;
        bus.item_in_valid = v;
        bus.item_in       = 8'h77;
        bus.pull_req      = r;
        @(posedge clock);
        #1;
        sb.delete();
        mlevel = 0;
        mcount = '0;
        mdata  = '0;
        check("rst_ready", 32'(bus.item_in_ready), 32'd1);
        check("rst_data", 32'(bus.pull_data), 32'd0);
        check("rst_ack", 32'(bus.pull_ack), 32'd0);
        check("rst_underflow", 32'(bus.pull_underflow), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_count", 32'(bus.recv_count), 32'd0);
        reset             = 1'b1;
        bus.item_in_valid = 1'b0;
        bus.pull_req      = 1'b0;
    endtask

    initial begin
        bus.item_in       = '0;
        bus.item_in_valid = 1'b0;
        bus.pull_req      = 1'b0;
        do_reset(1'b0, 1'b0);

        // single item
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        check("single_data", 32'(bus.pull_data), 32'hA5);
        check("single_count", 32'(bus.recv_count), 32'd1);
        check("single_level", 32'(bus.level), 32'd0);

        // fill, hold 0x05 against full, drain in order
        for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b0);
        check("full_ready", 32'(bus.item_in_ready), 32'd0);
        check("full_level", 32'(bus.level), 32'd4);
        cyc(1'b1, 8'h05, 1'b0);
        cyc(1'b1, 8'h05, 1'b1);
        check("fill_first", 32'(bus.pull_data), 32'h01);
        cyc(1'b1, 8'h05, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
        check("fill_last", 32'(bus.pull_data), 32'h05);

        // underflow, including one with a simultaneous push
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h33, 1'b1);
        check("uf_push_underflow", 32'(bus.pull_underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        check("uf_next_data", 32'(bus.pull_data), 32'h33);

        // steady push+pull at level 2, pointers wrap
        cyc(1'b1, 8'h10, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, DW'($urandom_range(0, 255)), 1'b1);
        check("steady_level", 32'(bus.level), 32'd2);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);

        // reset mid-operation at level 3 with a pull pending
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0);
        do_reset(1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);

        // counter wrap: 17 accepts with pulls interleaved
        for (int i = 0; i < 17; i++) cyc(1'b1, DW'(8'h40 + i), 1'b1);
        check("wrap_count", 32'(bus.recv_count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
